// File: rtl/cr_clic_pkg.sv
// Shared constants, candidate type and compare helpers for the CLIC scan arbiter.
package cr_clic_pkg;

  localparam int CLICINTNUM     = 80;
  localparam int CLICINTCTLBITS = 3;
  localparam int ID_WIDTH       = 12;
  localparam int GRP_SIZE       = 16;
  localparam int NUM_GRP        = (CLICINTNUM + GRP_SIZE - 1) / GRP_SIZE;
  localparam int GRP_CNT_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int PAD_NUM        = NUM_GRP * GRP_SIZE;
  localparam int KEY_W          = 9;
  localparam int IL_LOW_W       = 8 - CLICINTCTLBITS;

  typedef struct packed {
    logic                valid;
    logic                hv;
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          il;
    logic                mode;
  } cand_t;

  // Implemented ctl bits sit at the top of the level; unimplemented bits read as 1.
  function automatic logic [7:0] cand_level(input logic [CLICINTCTLBITS-1:0] ctl,
                                            input logic [CLICINTCTLBITS-1:0] mask);
    return {ctl | mask, {IL_LOW_W{1'b1}}};
  endfunction

  function automatic logic [KEY_W-1:0] cand_key(input cand_t c);
    return {c.mode, c.il};
  endfunction

  // hi always carries the larger ids, so taking it on an equal key gives larger-id-wins.
  function automatic cand_t cand_merge(input cand_t lo, input cand_t hi);
    if (hi.valid && (!lo.valid || (cand_key(hi) >= cand_key(lo))))
      return hi;
    return lo;
  endfunction

endpackage

// File: rtl/cr_clic_arb_grp.sv
// Combinational GRP_SIZE-way tree compare producing the winner of one source group.
module cr_clic_arb_grp
  import cr_clic_pkg::*;
(
  input  logic [GRP_SIZE-1:0]                grp_req,
  input  logic [GRP_SIZE*CLICINTCTLBITS-1:0] grp_ctl,
  input  logic [GRP_SIZE-1:0]                grp_hv,
  input  logic [GRP_SIZE-1:0]                grp_mode,
  input  logic [CLICINTCTLBITS-1:0]          lv_or_mask,
  input  logic [ID_WIDTH-1:0]                grp_base_id,
  output cand_t                              grp_cand
);

  localparam int LVLS = $clog2(GRP_SIZE);

  cand_t stage [LVLS+1][GRP_SIZE];

  // Level l+1 entry i reduces the adjacent pair 2i/2i+1 of level l, lower index on the left.
  always_comb begin
    for (int l = 0; l <= LVLS; l++)
      for (int i = 0; i < GRP_SIZE; i++)
        stage[l][i] = '0;
    for (int i = 0; i < GRP_SIZE; i++) begin
      stage[0][i].valid = grp_req[i];
      stage[0][i].hv    = grp_hv[i];
      stage[0][i].id    = grp_base_id + ID_WIDTH'(i);
      stage[0][i].il    = cand_level(grp_ctl[i*CLICINTCTLBITS +: CLICINTCTLBITS], lv_or_mask);
      stage[0][i].mode  = grp_mode[i];
    end
    for (int l = 0; l < LVLS; l++)
      for (int i = 0; i < GRP_SIZE/2; i++)
        if (i < (GRP_SIZE >> (l+1)))
          stage[l+1][i] = cand_merge(stage[l][2*i], stage[l][2*i+1]);
  end

  assign grp_cand = stage[LVLS][0];

endmodule

// File: rtl/cr_clic_arb_scan.sv
// Sequential CLIC scan arbiter: one source group per cycle, winner published every NUM_GRP cycles.
// Optional CR_CLIC_ARB_REVALIDATE_EN clears the published winner once its request drops.
module cr_clic_arb_scan
  import cr_clic_pkg::*;
(
  input  logic                                 arb_clk,
  input  logic                                 cpurst,
  input  logic [CLICINTNUM-1:0]                kid_arb_int_req,
  input  logic [CLICINTNUM*CLICINTCTLBITS-1:0] kid_arb_int_ctl,
  input  logic [CLICINTNUM-1:0]                kid_arb_int_hv,
  input  logic [CLICINTNUM-1:0]                kid_arb_int_mode,
  input  logic [CLICINTCTLBITS-1:0]            ctrl_xx_int_lv_or_mask,
  input  logic                                 cpu_clic_int_exit,
  output logic                                 arb_ctrl_int_hv,
  output logic [ID_WIDTH-1:0]                  arb_ctrl_int_id,
  output logic [7:0]                           arb_ctrl_int_il,
  output logic                                 arb_ctrl_int_mode,
  output logic                                 arb_scan_done
);

  logic [GRP_CNT_W-1:0]              grp_cnt;
  cand_t                             best_q;
  cand_t                             grp_cand;
  cand_t                             merged;
  logic                              last_grp;
  logic                              pub_clr;

  logic [PAD_NUM-1:0]                req_pad;
  logic [PAD_NUM-1:0]                hv_pad;
  logic [PAD_NUM-1:0]                mode_pad;
  logic [PAD_NUM*CLICINTCTLBITS-1:0] ctl_pad;

  logic [GRP_SIZE-1:0]                grp_req;
  logic [GRP_SIZE-1:0]                grp_hv;
  logic [GRP_SIZE-1:0]                grp_mode;
  logic [GRP_SIZE*CLICINTCTLBITS-1:0] grp_ctl;
  logic [ID_WIDTH-1:0]                grp_base_id;

  // Padding slots in the last group are tied off as never requesting.
  always_comb begin
    req_pad  = '0;
    hv_pad   = '0;
    mode_pad = '0;
    ctl_pad  = '0;
    req_pad[CLICINTNUM-1:0]                 = kid_arb_int_req;
    hv_pad[CLICINTNUM-1:0]                  = kid_arb_int_hv;
    mode_pad[CLICINTNUM-1:0]                = kid_arb_int_mode;
    ctl_pad[CLICINTNUM*CLICINTCTLBITS-1:0]  = kid_arb_int_ctl;
  end

  always_comb begin
    grp_req     = '0;
    grp_hv      = '0;
    grp_mode    = '0;
    grp_ctl     = '0;
    grp_base_id = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (grp_cnt == GRP_CNT_W'(g)) begin
        grp_req     = req_pad[g*GRP_SIZE +: GRP_SIZE];
        grp_hv      = hv_pad[g*GRP_SIZE +: GRP_SIZE];
        grp_mode    = mode_pad[g*GRP_SIZE +: GRP_SIZE];
        grp_ctl     = ctl_pad[g*GRP_SIZE*CLICINTCTLBITS +: GRP_SIZE*CLICINTCTLBITS];
        grp_base_id = ID_WIDTH'(g*GRP_SIZE);
      end
    end
  end

  cr_clic_arb_grp u_grp (
    .grp_req     (grp_req),
    .grp_ctl     (grp_ctl),
    .grp_hv      (grp_hv),
    .grp_mode    (grp_mode),
    .lv_or_mask  (ctrl_xx_int_lv_or_mask),
    .grp_base_id (grp_base_id),
    .grp_cand    (grp_cand)
  );

  assign merged   = cand_merge(best_q, grp_cand);
  assign last_grp = (grp_cnt == GRP_CNT_W'(NUM_GRP-1));

`ifdef CR_CLIC_ARB_REVALIDATE_EN
  logic win_req;

  always_comb begin
    win_req = 1'b0;
    for (int i = 0; i < CLICINTNUM; i++)
      if (arb_ctrl_int_id == ID_WIDTH'(i))
        win_req = kid_arb_int_req[i];
  end

  assign pub_clr = !win_req && (arb_ctrl_int_hv || (|arb_ctrl_int_il) || arb_ctrl_int_mode);
`else
  assign pub_clr = 1'b0;
`endif

  always_ff @(posedge arb_clk or posedge cpurst) begin
    if (cpurst) begin
      grp_cnt           <= '0;
      best_q            <= '0;
      arb_ctrl_int_hv   <= 1'b0;
      arb_ctrl_int_id   <= '0;
      arb_ctrl_int_il   <= '0;
      arb_ctrl_int_mode <= 1'b0;
      arb_scan_done     <= 1'b0;
    end else if (cpu_clic_int_exit) begin
      grp_cnt           <= '0;
      best_q            <= '0;
      arb_ctrl_int_hv   <= 1'b0;
      arb_ctrl_int_id   <= '0;
      arb_ctrl_int_il   <= '0;
      arb_ctrl_int_mode <= 1'b0;
      arb_scan_done     <= 1'b0;
    end else if (last_grp) begin
      grp_cnt           <= '0;
      best_q            <= '0;
      arb_ctrl_int_hv   <= merged.valid ? merged.hv   : 1'b0;
      arb_ctrl_int_id   <= merged.valid ? merged.id   : '0;
      arb_ctrl_int_il   <= merged.valid ? merged.il   : '0;
      arb_ctrl_int_mode <= merged.valid ? merged.mode : 1'b0;
      arb_scan_done     <= 1'b1;
    end else begin
      grp_cnt           <= grp_cnt + GRP_CNT_W'(1);
      best_q            <= merged;
      arb_scan_done     <= 1'b0;
      if (pub_clr) begin
        arb_ctrl_int_hv   <= 1'b0;
        arb_ctrl_int_id   <= '0;
        arb_ctrl_int_il   <= '0;
        arb_ctrl_int_mode <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cr_clic_arb_scan.sv
// Scoreboard bench for cr_clic_arb_scan; expected winners come from a flat reference scan.
module tb_cr_clic_arb_scan;
  import cr_clic_pkg::*;

  logic                                 arb_clk;
  logic                                 cpurst;
  logic [CLICINTNUM-1:0]                kid_arb_int_req;
  logic [CLICINTNUM*CLICINTCTLBITS-1:0] kid_arb_int_ctl;
  logic [CLICINTNUM-1:0]                kid_arb_int_hv;
  logic [CLICINTNUM-1:0]                kid_arb_int_mode;
  logic [CLICINTCTLBITS-1:0]            ctrl_xx_int_lv_or_mask;
  logic                                 cpu_clic_int_exit;
  logic                                 arb_ctrl_int_hv;
  logic [ID_WIDTH-1:0]                  arb_ctrl_int_id;
  logic [7:0]                           arb_ctrl_int_il;
  logic                                 arb_ctrl_int_mode;
  logic                                 arb_scan_done;

  typedef struct {
    logic                hv;
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          il;
    logic                mode;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_pub_cyc = 0;
  int   mark;

  cr_clic_arb_scan dut (
    .arb_clk                (arb_clk),
    .cpurst                 (cpurst),
    .kid_arb_int_req        (kid_arb_int_req),
    .kid_arb_int_ctl        (kid_arb_int_ctl),
    .kid_arb_int_hv         (kid_arb_int_hv),
    .kid_arb_int_mode       (kid_arb_int_mode),
    .ctrl_xx_int_lv_or_mask (ctrl_xx_int_lv_or_mask),
    .cpu_clic_int_exit      (cpu_clic_int_exit),
    .arb_ctrl_int_hv        (arb_ctrl_int_hv),
    .arb_ctrl_int_id        (arb_ctrl_int_id),
    .arb_ctrl_int_il        (arb_ctrl_int_il),
    .arb_ctrl_int_mode      (arb_ctrl_int_mode),
    .arb_scan_done          (arb_scan_done)
  );

  initial arb_clk = 1'b0;
  always #5 arb_clk = ~arb_clk;
  always @(posedge arb_clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flat reference: ascending scan, later source wins on key >=.
  function automatic exp_t model();
    exp_t       e;
    logic       found;
    logic [8:0] bkey, key;
    logic [7:0] il;
    e = '{hv: 1'b0, id: '0, il: '0, mode: 1'b0};
    found = 1'b0;
    bkey  = '0;
    for (int i = 0; i < CLICINTNUM; i++) begin
      if (kid_arb_int_req[i]) begin
        il  = {kid_arb_int_ctl[i*CLICINTCTLBITS +: CLICINTCTLBITS] | ctrl_xx_int_lv_or_mask,
               {IL_LOW_W{1'b1}}};
        key = {kid_arb_int_mode[i], il};
        if (!found || key >= bkey) begin
          found  = 1'b1;
          bkey   = key;
          e.hv   = kid_arb_int_hv[i];
          e.id   = ID_WIDTH'(i);
          e.il   = il;
          e.mode = kid_arb_int_mode[i];
        end
      end
    end
    return e;
  endfunction

  task automatic push_model(input int n);
    for (int k = 0; k < n; k++) sb.push_back(model());
  endtask

  task automatic restart();
    cpu_clic_int_exit = 1'b1;
    @(negedge arb_clk);
    cpu_clic_int_exit = 1'b0;
  endtask

  task automatic wait_pub(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge arb_clk);
      n++;
    end while (!arb_scan_done && n < 12);
    if (!arb_scan_done) begin
      chk({tag, "_timeout"}, 32'(arb_scan_done), 32'd1);
      return;
    end
    last_pub_cyc = cyc;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_hv"},   32'(arb_ctrl_int_hv),   32'(e.hv));
    chk({tag, "_id"},   32'(arb_ctrl_int_id),   32'(e.id));
    chk({tag, "_il"},   32'(arb_ctrl_int_il),   32'(e.il));
    chk({tag, "_mode"}, 32'(arb_ctrl_int_mode), 32'(e.mode));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hv"},   32'(arb_ctrl_int_hv),   32'd0);
    chk({tag, "_id"},   32'(arb_ctrl_int_id),   32'd0);
    chk({tag, "_il"},   32'(arb_ctrl_int_il),   32'd0);
    chk({tag, "_mode"}, 32'(arb_ctrl_int_mode), 32'd0);
    chk({tag, "_done"}, 32'(arb_scan_done),     32'd0);
  endtask

  task automatic set_src(input int i, input logic [2:0] ctl, input logic mode, input logic hv);
    kid_arb_int_req[i] = 1'b1;
    kid_arb_int_ctl[i*CLICINTCTLBITS +: CLICINTCTLBITS] = ctl;
    kid_arb_int_mode[i] = mode;
    kid_arb_int_hv[i]   = hv;
  endtask

  task automatic clr_all();
    kid_arb_int_req        = '0;
    kid_arb_int_ctl        = '0;
    kid_arb_int_hv         = '0;
    kid_arb_int_mode       = '0;
    ctrl_xx_int_lv_or_mask = '0;
  endtask

  initial begin
    cpurst = 1'b1;
    cpu_clic_int_exit = 1'b0;
    clr_all();
    repeat (3) @(negedge arb_clk);
    chk_zero("reset");
    cpurst = 1'b0;

    // single source 37
    set_src(37, 3'b101, 1'b1, 1'b1);
    restart();
    push_model(3);
    wait_pub("t1_p0");
    chk("t1_id_const", 32'(arb_ctrl_int_id), 32'd37);
    chk("t1_il_const", 32'(arb_ctrl_int_il), 32'hBF);
    mark = last_pub_cyc;
    wait_pub("t1_p1");
    chk("t1_gap1", 32'(last_pub_cyc - mark), 32'd5);
    mark = last_pub_cyc;
    wait_pub("t1_p2");
    chk("t1_gap2", 32'(last_pub_cyc - mark), 32'd5);

    // reset mid-scan returns to reset state and restarts at group 0
    repeat (2) @(negedge arb_clk);
    cpurst = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(negedge arb_clk);
    cpurst = 1'b0;
    mark = cyc;
    push_model(1);
    wait_pub("rst_pub");
    chk("rst_gap", 32'(last_pub_cyc - mark), 32'd5);

    // tie: equal key, larger id wins
    clr_all();
    set_src(5,  3'b110, 1'b1, 1'b0);
    set_src(70, 3'b110, 1'b1, 1'b0);
    restart();
    push_model(1);
    wait_pub("tie");
    chk("tie_id_const", 32'(arb_ctrl_int_id), 32'd70);

    kid_arb_int_mode[70] = 1'b0;
    restart();
    push_model(1);
    wait_pub("mode");
    chk("mode_id_const", 32'(arb_ctrl_int_id), 32'd5);

    set_src(5,  3'b111, 1'b0, 1'b0);
    set_src(70, 3'b000, 1'b1, 1'b1);
    restart();
    push_model(1);
    wait_pub("mode_vs_lvl");
    chk("mvl_id_const", 32'(arb_ctrl_int_id), 32'd70);

    // level OR-mask
    clr_all();
    ctrl_xx_int_lv_or_mask = 3'b011;
    set_src(12, 3'b000, 1'b0, 1'b0);
    restart();
    push_model(1);
    wait_pub("mask");
    chk("mask_il_const", 32'(arb_ctrl_int_il), 32'h7F);

    // flush exactly on the publish cycle (grp_cnt = 4)
    repeat (4) @(negedge arb_clk);
    cpu_clic_int_exit = 1'b1;
    @(negedge arb_clk);
    cpu_clic_int_exit = 1'b0;
    chk_zero("flush_pub");
    mark = cyc;
    push_model(1);
    wait_pub("flush_next");
    chk("flush_gap", 32'(last_pub_cyc - mark), 32'd5);

    // empty request vector
    clr_all();
    kid_arb_int_ctl  = '1;
    kid_arb_int_mode = '1;
    kid_arb_int_hv   = '1;
    restart();
    push_model(2);
    wait_pub("empty0");
    wait_pub("empty1");

    // winner drops after publish
    clr_all();
    set_src(20, 3'b010, 1'b1, 1'b1);
    restart();
    push_model(1);
    wait_pub("reval_pub");
    @(negedge arb_clk);
    chk("reval_p1_id", 32'(arb_ctrl_int_id), 32'd20);
    kid_arb_int_req[20] = 1'b0;
    @(negedge arb_clk);
`ifdef CR_CLIC_ARB_REVALIDATE_EN
    chk("reval_p2_id", 32'(arb_ctrl_int_id), 32'd0);
    chk("reval_p2_il", 32'(arb_ctrl_int_il), 32'd0);
`else
    chk("hold_p2_id", 32'(arb_ctrl_int_id), 32'd20);
    chk("hold_p2_il", 32'(arb_ctrl_int_il), 32'h5F);
`endif
    push_model(1);
    wait_pub("reval_next");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
